// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RISC-V integer types for the register file, ALU and decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int XLEN           = 32;
    localparam int REG_COUNT      = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef logic [XLEN-1:0]           word_t;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage : riscv_pkg

`default_nettype wire

// File: rtl/reg_file_assert.sv
// ============================================================================
// Module      : reg_file_assert
// Description : Property checker for reg_file, attached to the design with bind.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_assert #(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_REGS   = 32,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_reg,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_reg_1,
    input  logic [ADDR_WIDTH-1:0] rd_reg_2,
    input  logic [DATA_WIDTH-1:0] rd_data_1,
    input  logic [DATA_WIDTH-1:0] rd_data_2
);

    logic                  r_last_valid;
    logic                  r_last_wr_en;
    logic [ADDR_WIDTH-1:0] r_last_wr_reg;
    logic [DATA_WIDTH-1:0] r_last_wr_data;
    logic [ADDR_WIDTH-1:0] r_last_rd_reg_1;
    logic [DATA_WIDTH-1:0] r_last_rd_data_1;
    logic                  w_cur_wr_match_1;
    logic                  w_last_in_range;

    // Snapshot of the inputs and read port 1 as seen at the last active edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_valid     <= 1'b0;
            r_last_wr_en     <= 1'b0;
            r_last_wr_reg    <= '0;
            r_last_wr_data   <= '0;
            r_last_rd_reg_1  <= '0;
            r_last_rd_data_1 <= '0;
        end else begin
            r_last_valid     <= 1'b1;
            r_last_wr_en     <= wr_en;
            r_last_wr_reg    <= wr_reg;
            r_last_wr_data   <= wr_data;
            r_last_rd_reg_1  <= rd_reg_1;
            r_last_rd_data_1 <= rd_data_1;
        end
    end

    // A pending write to the port-1 register may be forwarded; skip those cycles.
    assign w_cur_wr_match_1 = wr_en && (wr_reg != '0) && (wr_reg == rd_reg_1);
    assign w_last_in_range  = ({1'b0, r_last_wr_reg} < (ADDR_WIDTH + 1)'(NUM_REGS));

    a_x0_port1 : assert property (@(negedge clk)
        (rd_reg_1 == '0) |-> (rd_data_1 == '0));

    a_x0_port2 : assert property (@(negedge clk)
        (rd_reg_2 == '0) |-> (rd_data_2 == '0));

    a_write_visible : assert property (@(negedge clk) disable iff (!rst_n)
        (r_last_valid && r_last_wr_en && (r_last_wr_reg != '0) && w_last_in_range
         && (r_last_wr_reg == rd_reg_1) && !w_cur_wr_match_1)
        |-> (rd_data_1 == r_last_wr_data));

    a_hold_no_wr_en : assert property (@(negedge clk) disable iff (!rst_n)
        (r_last_valid && !r_last_wr_en && (r_last_rd_reg_1 == rd_reg_1)
         && !w_cur_wr_match_1)
        |-> (rd_data_1 == r_last_rd_data_1));

endmodule : reg_file_assert

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// Module      : reg_file
// Description : RISC-V integer register file, 2 combinational reads, 1 write,
//               x0 hardwired to zero. Optional macro REG_FILE_BYPASS_EN enables
//               write-first forwarding onto the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file
    import riscv_pkg::*;
#(
    parameter  int DATA_WIDTH = XLEN,
    parameter  int NUM_REGS   = REG_COUNT,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_reg,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_reg_1,
    input  logic [ADDR_WIDTH-1:0] rd_reg_2,
    output logic [DATA_WIDTH-1:0] rd_data_1,
    output logic [DATA_WIDTH-1:0] rd_data_2
);

    // x0 has no storage; index 0 always falls through to the zero default.
    logic [DATA_WIDTH-1:0] r_regs [1:NUM_REGS-1];

    logic                  w_wr_in_range;
    logic                  w_wr_hit;
    logic                  w_fwd_1;
    logic                  w_fwd_2;
    logic [DATA_WIDTH-1:0] w_rd_data_1;
    logic [DATA_WIDTH-1:0] w_rd_data_2;

    generate
        if ((1 << ADDR_WIDTH) == NUM_REGS) begin : g_pow2
            assign w_wr_in_range = 1'b1;
        end else begin : g_npow2
            assign w_wr_in_range = (wr_reg < ADDR_WIDTH'(NUM_REGS));
        end
    endgenerate

    assign w_wr_hit = wr_en && (wr_reg != '0) && w_wr_in_range;

    generate
        for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_regs[g] <= '0;
                end else if (w_wr_hit && (wr_reg == ADDR_WIDTH'(g))) begin
                    r_regs[g] <= wr_data;
                end
            end
        end
    endgenerate

`ifdef REG_FILE_BYPASS_EN
    assign w_fwd_1 = w_wr_hit && (wr_reg == rd_reg_1);
    assign w_fwd_2 = w_wr_hit && (wr_reg == rd_reg_2);
`else
    assign w_fwd_1 = 1'b0;
    assign w_fwd_2 = 1'b0;
`endif

    // Out-of-range and x0 indices match no entry and read as zero.
    always_comb begin
        w_rd_data_1 = '0;
        w_rd_data_2 = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rd_reg_1 == ADDR_WIDTH'(i)) begin
                w_rd_data_1 = r_regs[i];
            end
            if (rd_reg_2 == ADDR_WIDTH'(i)) begin
                w_rd_data_2 = r_regs[i];
            end
        end
        if (w_fwd_1) begin
            w_rd_data_1 = wr_data;
        end
        if (w_fwd_2) begin
            w_rd_data_2 = wr_data;
        end
    end

    assign rd_data_1 = w_rd_data_1;
    assign rd_data_2 = w_rd_data_2;

endmodule : reg_file

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// Module      : tb_reg_file
// Description : Self-checking bench for reg_file against an array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file;
    import riscv_pkg::*;

    logic      clk;
    logic      rst_n;
    logic      wr_en;
    reg_addr_t wr_reg;
    word_t     wr_data;
    reg_addr_t rd_reg_1;
    reg_addr_t rd_reg_2;
    word_t     rd_data_1;
    word_t     rd_data_2;

    int    vectors;
    int    miscompares;
    word_t model [REG_COUNT];

    reg_file u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .rd_reg_1  (rd_reg_1),
        .rd_reg_2  (rd_reg_2),
        .rd_data_1 (rd_data_1),
        .rd_data_2 (rd_data_2)
    );

    bind reg_file reg_file_assert u_assert (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .rd_reg_1  (rd_reg_1),
        .rd_reg_2  (rd_reg_2),
        .rd_data_1 (rd_data_1),
        .rd_data_2 (rd_data_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural read: x0 is zero, otherwise stored value, optionally forwarded.
    function automatic word_t exp_rd(input reg_addr_t idx);
        if (idx == REG_ZERO) return '0;
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && (wr_reg == idx)) return wr_data;
`endif
        return model[idx];
    endfunction

    // Advance one clock, updating the model exactly as an architectural write would.
    task automatic tick();
        @(posedge clk);
        if (rst_n && wr_en && (wr_reg != REG_ZERO)) model[wr_reg] = wr_data;
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < REG_COUNT; i++) model[i] = '0;
    endtask

    task automatic do_write(input reg_addr_t r, input word_t d);
        wr_en = 1'b1; wr_reg = r; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_model();
        rd_reg_1 = 5'd5; rd_reg_2 = 5'd31;
        #1;
        vectors++;
        if (rd_data_1 !== 32'h0 || rd_data_2 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state: got %h/%h, expected 0/0", rd_data_1, rd_data_2);
        end
        tick();
        rst_n = 1'b1;
        tick();
        do_write(5'd5, 32'hDEAD_BEEF);
        #1;
        vectors++;
        if (rd_data_1 !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL reset_prewrite: got %h, expected deadbeef", rd_data_1);
        end
        // Asynchronous pulse between edges must clear immediately.
        #1 rst_n = 1'b0;
        clear_model();
        #1;
        vectors++;
        if (rd_data_1 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_async: got %h, expected 0", rd_data_1);
        end
        rst_n = 1'b1;
        tick();
        // Reset held across a write edge: the write is lost.
        wr_en = 1'b1; wr_reg = 5'd6; wr_data = 32'hCAFE_F00D; rd_reg_1 = 5'd6;
        rst_n = 1'b0;
        tick();
        wr_en = 1'b0;
        #1;
        vectors++;
        if (rd_data_1 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_write: got %h, expected 0", rd_data_1);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        do_write(5'd1, 32'h1234_5678);
        do_write(5'd31, 32'hFFFF_FFFF);
        rd_reg_1 = 5'd1; rd_reg_2 = 5'd31;
        #1;
        vectors++;
        if (rd_data_1 !== 32'h1234_5678 || rd_data_2 !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL write_read: got %h/%h, expected 12345678/ffffffff", rd_data_1, rd_data_2);
        end
    endtask

    task automatic test_x0();
        wr_en = 1'b1; wr_reg = 5'd0; wr_data = 32'hFFFF_FFFF;
        rd_reg_1 = 5'd0; rd_reg_2 = 5'd0;
        #1;
        vectors++;
        if (rd_data_1 !== 32'h0 || rd_data_2 !== 32'h0) begin
            miscompares++;
            $display("FAIL x0_same_cycle: got %h/%h, expected 0/0", rd_data_1, rd_data_2);
        end
        tick();
        wr_en = 1'b0;
        #1;
        vectors++;
        if (rd_data_1 !== 32'h0 || rd_data_2 !== 32'h0) begin
            miscompares++;
            $display("FAIL x0_after_write: got %h/%h, expected 0/0", rd_data_1, rd_data_2);
        end
    endtask

    task automatic test_dual_port();
        word_t alu_and;
        do_write(5'd7, 32'h00FF_00FF);
        rd_reg_1 = 5'd7; rd_reg_2 = 5'd7;
        #1;
        alu_and = rd_data_1 & rd_data_2;
        vectors++;
        if (rd_data_1 !== 32'h00FF_00FF || rd_data_2 !== 32'h00FF_00FF) begin
            miscompares++;
            $display("FAIL dual_port: got %h/%h, expected 00ff00ff/00ff00ff", rd_data_1, rd_data_2);
        end
        vectors++;
        if (alu_and !== 32'h00FF_00FF) begin
            miscompares++;
            $display("FAIL alu_and: got %h, expected 00ff00ff", alu_and);
        end
    endtask

    task automatic test_same_cycle();
        word_t exp_now;
        do_write(5'd3, 32'h5);
`ifdef REG_FILE_BYPASS_EN
        exp_now = 32'hA;
`else
        exp_now = 32'h5;
`endif
        wr_en = 1'b1; wr_reg = 5'd3; wr_data = 32'hA; rd_reg_1 = 5'd3; rd_reg_2 = 5'd1;
        #1;
        vectors++;
        if (rd_data_1 !== exp_now || rd_data_2 !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL same_cycle: got %h/%h, expected %h/12345678", rd_data_1, rd_data_2, exp_now);
        end
        tick();
        wr_en = 1'b0;
        #1;
        vectors++;
        if (rd_data_1 !== 32'hA) begin
            miscompares++;
            $display("FAIL same_cycle_next: got %h, expected 0000000a", rd_data_1);
        end
    endtask

    task automatic test_hold();
        do_write(5'd4, 32'h99);
        wr_en = 1'b0; wr_reg = 5'd4; wr_data = 32'h1; rd_reg_1 = 5'd4; rd_reg_2 = 5'd4;
        for (int c = 0; c < 10; c++) begin
            tick();
            #1;
            vectors++;
            if (rd_data_1 !== 32'h99 || rd_data_2 !== 32'h99) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: got %h/%h, expected 99/99", c, rd_data_1, rd_data_2);
            end
        end
    endtask

    task automatic test_random();
        word_t e1;
        word_t e2;
        for (int c = 0; c < 300; c++) begin
            wr_en    = ($urandom_range(0, 2) != 0);
            wr_reg   = reg_addr_t'($urandom_range(0, REG_COUNT - 1));
            wr_data  = $urandom;
            rd_reg_1 = reg_addr_t'($urandom_range(0, REG_COUNT - 1));
            // Bias port 2 toward the write target to exercise forwarding.
            rd_reg_2 = ($urandom_range(0, 3) == 0) ? wr_reg
                                                   : reg_addr_t'($urandom_range(0, REG_COUNT - 1));
            #1;
            e1 = exp_rd(rd_reg_1);
            e2 = exp_rd(rd_reg_2);
            vectors++;
            if (rd_data_1 !== e1 || rd_data_2 !== e2) begin
                miscompares++;
                $display("FAIL random_%0d: x%0d/x%0d got %h/%h, expected %h/%h",
                         c, rd_reg_1, rd_reg_2, rd_data_1, rd_data_2, e1, e2);
            end
            tick();
        end
        wr_en = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        wr_en       = 1'b0;
        wr_reg      = '0;
        wr_data     = '0;
        rd_reg_1    = '0;
        rd_reg_2    = '0;
        test_reset();
        test_write_read();
        test_x0();
        test_dual_port();
        test_same_cycle();
        test_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_reg_file

`default_nettype wire
